// File: rtl/mc6809_bus_pkg.sv
// Shared definitions for the 6809 bus target: register offsets, CTRL bit
// positions, wait-counter width and the latched bus-cycle record.
package mc6809_bus_pkg;

   typedef enum logic [1:0] {
      OFF_SCRATCH = 2'd0,
      OFF_CTRL    = 2'd1,
      OFF_RELOAD  = 2'd2,
      OFF_STATUS  = 2'd3
   } reg_off_e;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_IRQEN = 1;
   localparam int CTRL_AUTO  = 2;

   localparam int WAIT_W = 4;

   // What the target remembers about the cycle started at the last Q rise.
   typedef struct packed {
      logic     sel;
      logic     rnw;
      reg_off_e off;
   } cyc_t;

endpackage

// File: rtl/mc6809_e_timer.sv
// E-cycle down-counter with underflow flag.
//   gclk, grst_n : clock, async active-low reset
//   tick         : one pulse per E cycle, already qualified by CTRL.en
//   load         : load count from reload (has priority over tick)
//   clear        : clear flag (an underflow in the same cycle wins)
//   reload       : reload value
//   auto_mode    : reload on underflow instead of stopping
//   count        : architecturally visible count bits [6:0]
//   flag         : sticky underflow flag
//   underflow    : tick arrived with count == 0
//   en_clear     : underflow in one-shot mode, CTRL.en must drop
module mc6809_e_timer (
   input  logic       gclk,
   input  logic       grst_n,
   input  logic       tick,
   input  logic       load,
   input  logic       clear,
   input  logic [7:0] reload,
   input  logic       auto_mode,
   output logic [6:0] count,
   output logic       flag,
   output logic       underflow,
   output logic       en_clear
);

   logic [7:0] count_q, count_d;
   logic       flag_q, flag_d;

   always_comb begin
      underflow = tick & (count_q == 8'd0);
      en_clear  = underflow & ~auto_mode;
      count_d   = count_q;
      if (load || (underflow && auto_mode))
         count_d = reload;
      else if (tick && !underflow)
         count_d = count_q - 8'd1;
      flag_d = underflow | (flag_q & ~clear);
   end

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         count_q <= 8'd0;
         flag_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         flag_q  <= flag_d;
      end
   end

   assign count = count_q[6:0];
   assign flag  = flag_q;

endmodule

// File: rtl/mc6809_bus_target.sv
// 4-byte register peripheral on the 6809 bus, clocked by the 4x oscillator.
//   gclk, grst_n : oscillator clock, async active-low reset
//   E, Q         : bus phase clocks from the CPU wrapper
//   ADDR, RnW    : address and direction, sampled at Q rise
//   DIn          : CPU write data, committed at E fall
//   DOut, DOE    : read data and its mux enable toward the CPU
//   MRDY         : wait request, low freezes E/Q in the wrapper
//   nIRQ         : active-low timer interrupt
module mc6809_bus_target
   import mc6809_bus_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR      = 16'hFF00,
   parameter int          WAIT_STATES    = 0,
   parameter logic        IRQ_DEFAULT_EN = 1'b0
) (
   input  logic        gclk,
   input  logic        grst_n,
   input  logic        E,
   input  logic        Q,
   input  logic [15:0] ADDR,
   input  logic        RnW,
   input  logic [7:0]  DIn,
   output logic [7:0]  DOut,
   output logic        DOE,
   output logic        MRDY,
   output logic        nIRQ
);

   localparam logic [WAIT_W-1:0] WAIT_N = WAIT_W'(WAIT_STATES);

   logic              e_q, q_q;
   cyc_t              cyc_q, cyc_d;
   logic [7:0]        dout_q, dout_d;
   logic              doe_q, doe_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [7:0]        scratch_q, scratch_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic [7:0]        reload_q, reload_d;
   logic              nirq_q, nirq_d;

   logic       addr_phase, commit, sel;
   logic       wr, wr_ctrl, wr_status;
   logic [7:0] rd_mux;
   logic       tmr_tick, tmr_load, tmr_clear;
   logic [6:0] tmr_count;
   logic       tmr_flag, tmr_uf, tmr_en_clear;

   mc6809_e_timer u_timer (
      .gclk      (gclk),
      .grst_n    (grst_n),
      .tick      (tmr_tick),
      .load      (tmr_load),
      .clear     (tmr_clear),
      .reload    (reload_q),
      .auto_mode (ctrl_q[CTRL_AUTO]),
      .count     (tmr_count),
      .flag      (tmr_flag),
      .underflow (tmr_uf),
      .en_clear  (tmr_en_clear)
   );

   always_comb begin
      addr_phase = Q & ~q_q & ~E;
      commit     = ~E & e_q;
      sel        = (ADDR[15:2] == BASE_ADDR[15:2]);

      case (ADDR[1:0])
         OFF_SCRATCH: rd_mux = scratch_q;
         OFF_CTRL:    rd_mux = {5'b0, ctrl_q};
         OFF_RELOAD:  rd_mux = reload_q;
         default:     rd_mux = {tmr_count, tmr_flag};
      endcase

      wr        = commit & cyc_q.sel & ~cyc_q.rnw;
      wr_ctrl   = wr & (cyc_q.off == OFF_CTRL);
      wr_status = wr & (cyc_q.off == OFF_STATUS);

      tmr_tick  = commit & ctrl_q[CTRL_EN];
      tmr_clear = wr_status & DIn[0];
      // Setting en reloads when en was off, or when this very tick is an
      // underflow (one-shot: the write keeps en alive; auto: same reload).
      tmr_load  = wr_ctrl & DIn[CTRL_EN] & (~ctrl_q[CTRL_EN] | tmr_uf);

      cyc_d = cyc_q;
      if (addr_phase) cyc_d = '{sel: sel, rnw: RnW, off: reg_off_e'(ADDR[1:0])};

      dout_d = dout_q;
      doe_d  = doe_q;
      if (addr_phase && sel && RnW) begin
         dout_d = rd_mux;
         doe_d  = 1'b1;
      end else if (commit) begin
         doe_d  = 1'b0;
      end

      wait_d = wait_q;
      if (addr_phase && sel)   wait_d = WAIT_N;
      else if (wait_q != '0)   wait_d = wait_q - 1'b1;

      scratch_d = scratch_q;
      reload_d  = reload_q;
      ctrl_d    = ctrl_q;
      if (tmr_en_clear) ctrl_d[CTRL_EN] = 1'b0;
      if (wr) begin
         case (cyc_q.off)
            OFF_SCRATCH: scratch_d = DIn;
            OFF_CTRL:    ctrl_d    = DIn[2:0];
            OFF_RELOAD:  reload_d  = DIn;
            default:     ;
         endcase
      end

      nirq_d = ~(tmr_flag & ctrl_q[CTRL_IRQEN]);
   end

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         e_q       <= 1'b0;
         q_q       <= 1'b0;
         cyc_q     <= '{sel: 1'b0, rnw: 1'b1, off: OFF_SCRATCH};
         dout_q    <= 8'd0;
         doe_q     <= 1'b0;
         wait_q    <= '0;
         scratch_q <= 8'd0;
         ctrl_q    <= {1'b0, IRQ_DEFAULT_EN, 1'b0};
         reload_q  <= 8'd0;
         nirq_q    <= 1'b1;
      end else begin
         e_q       <= E;
         q_q       <= Q;
         cyc_q     <= cyc_d;
         dout_q    <= dout_d;
         doe_q     <= doe_d;
         wait_q    <= wait_d;
         scratch_q <= scratch_d;
         ctrl_q    <= ctrl_d;
         reload_q  <= reload_d;
         nirq_q    <= nirq_d;
      end
   end

   assign DOut = dout_q;
   assign DOE  = doe_q;
   // Driven straight from the counter so reset releases a frozen bus at once.
   assign MRDY = (wait_q == '0);
   assign nIRQ = nirq_q;

endmodule

// File: tb/tb_mc6809_bus_target.sv
module tb_mc6809_bus_target;

   localparam int WS = 3;

   logic        gclk = 1'b0;
   logic        grst_n = 1'b1;
   logic        E = 1'b0, Q = 1'b0, RnW = 1'b1;
   logic [15:0] ADDR = 16'h0000;
   logic [7:0]  DIn = 8'h00;
   logic [7:0]  DOut;
   logic        DOE, MRDY, nIRQ;

   mc6809_bus_target #(
      .BASE_ADDR      (16'hFF00),
      .WAIT_STATES    (WS),
      .IRQ_DEFAULT_EN (1'b0)
   ) dut (
      .gclk   (gclk),
      .grst_n (grst_n),
      .E      (E),
      .Q      (Q),
      .ADDR   (ADDR),
      .RnW    (RnW),
      .DIn    (DIn),
      .DOut   (DOut),
      .DOE    (DOE),
      .MRDY   (MRDY),
      .nIRQ   (nIRQ)
   );

   always #5 gclk = ~gclk;

   int errs = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Register-level model: state after the last E fall.
   logic [7:0] m_scratch, m_reload, m_count, m_dout;
   logic [2:0] m_ctrl;
   logic       m_flag;

   task automatic m_reset();
      m_scratch = 0; m_reload = 0; m_count = 0; m_dout = 0; m_ctrl = 3'b000; m_flag = 0;
   endtask

   function automatic logic [7:0] m_read(input logic [1:0] off);
      case (off)
         2'd0:    return m_scratch;
         2'd1:    return {5'b0, m_ctrl};
         2'd2:    return m_reload;
         default: return {m_count[6:0], m_flag};
      endcase
   endfunction

   // One E fall: status clear, then the timer tick, then the register write.
   task automatic m_commit(input bit wr, input logic [1:0] off, input logic [7:0] d);
      bit uf;
      uf = m_ctrl[0] && (m_count == 0);
      if (wr && off == 2'd3 && d[0] && !uf) m_flag = 0;
      if (m_ctrl[0]) begin
         if (m_count != 0) m_count = m_count - 1;
         else begin
            m_flag = 1;
            if (m_ctrl[2]) m_count = m_reload;
            else m_ctrl[0] = 0;
         end
      end
      if (wr) begin
         case (off)
            2'd0: m_scratch = d;
            2'd1: begin
               if (d[0] && !m_ctrl[0]) m_count = m_reload;
               m_ctrl = d[2:0];
            end
            2'd2: m_reload = d;
            default: ;
         endcase
      end
   endtask

   // One full E cycle as the wrapper would run it, honouring MRDY.
   task automatic bus(input logic [15:0] a, input bit rnw, input logic [7:0] d,
                      output logic [7:0] rd);
      bit sel;
      bit irq_exp;
      int st;
      sel = (a[15:2] == 14'h3FC0);
      st  = 0;
      ADDR = a; RnW = rnw; DIn = d;
      @(posedge gclk); #1;
      irq_exp = !(m_flag && m_ctrl[1]);
      chk("nirq", nIRQ, irq_exp);
      Q = 1'b1;
      @(posedge gclk); #1;
      while (!MRDY && st < 20) begin
         st++;
         @(posedge gclk); #1;
      end
      chk("mrdy_stretch", st, sel ? WS : 0);
      chk("doe_rise", DOE, sel && rnw);
      rd = DOut;
      if (sel && rnw) begin
         m_dout = m_read(a[1:0]);
         chk("dout", DOut, m_dout);
      end
      E = 1'b1;
      @(posedge gclk); #1;
      Q = 1'b0;
      @(posedge gclk); #1;
      chk("doe_hold", DOE, sel && rnw);
      E = 1'b0;
      @(posedge gclk); #1;
      m_commit(sel && !rnw, a[1:0], d);
      chk("doe_fall", DOE, 0);
      chk("dout_keep", DOut, m_dout);
      chk("mrdy_idle", MRDY, 1);
   endtask

   typedef struct {
      logic [15:0] a;
      bit          rnw;
      logic [7:0]  d;
      bit          ck;
      logic [7:0]  exp;
   } vec_t;

   vec_t tbl[19];

   initial begin
      logic [7:0] rd;
      logic [15:0] ra;

      tbl[0]  = '{16'hFF00, 1, 8'h00, 1, 8'h00};
      tbl[1]  = '{16'hFF01, 1, 8'h00, 1, 8'h00};
      tbl[2]  = '{16'hFF02, 1, 8'h00, 1, 8'h00};
      tbl[3]  = '{16'hFF03, 1, 8'h00, 1, 8'h00};
      tbl[4]  = '{16'hFF00, 0, 8'hA5, 0, 8'h00};
      tbl[5]  = '{16'hFF00, 1, 8'h00, 1, 8'hA5};
      tbl[6]  = '{16'hFF01, 1, 8'h00, 1, 8'h00};
      tbl[7]  = '{16'hFE00, 0, 8'h5A, 0, 8'h00};
      tbl[8]  = '{16'hFE00, 1, 8'h00, 0, 8'h00};
      tbl[9]  = '{16'hFF00, 1, 8'h00, 1, 8'hA5};
      tbl[10] = '{16'hFF01, 0, 8'hF8, 0, 8'h00};
      tbl[11] = '{16'hFF01, 1, 8'h00, 1, 8'h00};
      tbl[12] = '{16'hFF02, 0, 8'h3C, 0, 8'h00};
      tbl[13] = '{16'hFF02, 1, 8'h00, 1, 8'h3C};
      tbl[14] = '{16'hFF03, 0, 8'hFE, 0, 8'h00};
      tbl[15] = '{16'hFF03, 1, 8'h00, 1, 8'h00};
      tbl[16] = '{16'hFF01, 0, 8'h06, 0, 8'h00};
      tbl[17] = '{16'hFF01, 1, 8'h00, 1, 8'h06};
      tbl[18] = '{16'hFF01, 0, 8'h00, 0, 8'h00};

      m_reset();
      #1 grst_n = 1'b0;
      #11;
      chk("rst_dout", DOut, 8'h00);
      chk("rst_doe", DOE, 0);
      chk("rst_mrdy", MRDY, 1);
      chk("rst_nirq", nIRQ, 1);
      @(negedge gclk) grst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         bus(tbl[i].a, tbl[i].rnw, tbl[i].d, rd);
         if (tbl[i].ck) chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
      end

      // One-shot: RELOAD=2, enable with irq -> flag on the 3rd tick.
      bus(16'hFF02, 0, 8'h02, rd);
      bus(16'hFF01, 0, 8'h03, rd);
      bus(16'h0000, 1, 8'h00, rd);
      bus(16'h0000, 1, 8'h00, rd);
      chk("os_no_irq_yet", nIRQ, 1);
      bus(16'h0000, 1, 8'h00, rd);
      chk("os_irq_lag", nIRQ, 1);
      bus(16'hFF01, 1, 8'h00, rd);
      chk("os_ctrl", rd, 8'h02);
      chk("os_irq", nIRQ, 0);
      bus(16'hFF03, 1, 8'h00, rd);
      chk("os_status", rd, 8'h01);
      bus(16'hFF03, 0, 8'h01, rd);
      bus(16'h0000, 1, 8'h00, rd);
      chk("os_irq_clr", nIRQ, 1);

      // Auto-reload every tick; clear collides with an underflow.
      bus(16'hFF02, 0, 8'h00, rd);
      bus(16'hFF01, 0, 8'h07, rd);
      bus(16'h0000, 1, 8'h00, rd);
      bus(16'hFF03, 0, 8'h01, rd);
      bus(16'hFF03, 1, 8'h00, rd);
      chk("auto_set_wins", rd, 8'h01);
      chk("auto_irq_held", nIRQ, 0);

      // CTRL en write colliding with a one-shot underflow: count reloads.
      bus(16'hFF01, 0, 8'h00, rd);
      bus(16'hFF03, 0, 8'h01, rd);
      bus(16'hFF02, 0, 8'h01, rd);
      bus(16'hFF01, 0, 8'h03, rd);
      bus(16'h0000, 1, 8'h00, rd);
      bus(16'hFF01, 0, 8'h03, rd);
      bus(16'hFF03, 1, 8'h00, rd);
      chk("col_status", rd, 8'h03);
      bus(16'hFF01, 1, 8'h00, rd);
      chk("col_ctrl", rd, 8'h03);

      // Reset in the middle of a stretched read.
      bus(16'hFF00, 0, 8'h77, rd);
      ADDR = 16'hFF00; RnW = 1'b1;
      @(posedge gclk); #1;
      Q = 1'b1;
      @(posedge gclk); #1;
      chk("mid_mrdy_low", MRDY, 0);
      chk("mid_doe", DOE, 1);
      chk("mid_irq", nIRQ, 0);
      #2 grst_n = 1'b0;
      #1;
      chk("mid_rst_mrdy", MRDY, 1);
      chk("mid_rst_doe", DOE, 0);
      chk("mid_rst_dout", DOut, 8'h00);
      chk("mid_rst_nirq", nIRQ, 1);
      E = 1'b0; Q = 1'b0;
      m_reset();
      @(negedge gclk) grst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus(16'hFF00 + 16'(i), 1, 8'h00, rd);
         chk($sformatf("post_rst%0d", i), rd, 8'h00);
      end

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) ra = 16'($urandom);
         else ra = 16'hFF00 | 16'($urandom_range(0, 3));
         bus(ra, bit'($urandom_range(0, 1)), 8'($urandom), rd);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
